regfile_host_ctrl: RTL and testbench

- Word-serial host front end for the coprocessor register file; successor of the fixed 32-bit/16-register controller.
- Decodes a header word, then either streams a register out as WORD_W-bit words, or assembles incoming words and commits them with a one-cycle one-hot write enable.
- Generalised in word width, register width, register count and per-register length; adds valid/ready handshakes on both host channels.

---
 rtl/regfile_host_ctrl_pkg.sv | 41 ++++
 rtl/regfile_host_ctrl_if.sv | 22 ++
 rtl/regfile_host_ctrl_word_shadow_buf.sv | 41 ++++
 rtl/regfile_host_ctrl.sv | 168 ++++++++++++++++
 tb/tb_regfile_host_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_host_ctrl_pkg.sv
// Shared types and helpers for the word-serial register-file host controller.
package regfile_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LOAD,
        RD_SEND,
        WR_FILL,
        WR_COMMIT
    } ctrlState_t;

    // Header fields are positioned relative to the word MSB: op at WORD_W-1, reg select at WORD_W-2 downward.
    localparam int unsigned HDR_OP_OFS  = 1;
    localparam int unsigned HDR_SEL_OFS = 2;

    localparam int unsigned LEN_TABLE_MAX_W = 4096;

    // Words per register for entry regIdx: zero reads as one, oversize entries saturate at maxLen.
    function automatic int unsigned len_lookup(
        input logic [LEN_TABLE_MAX_W-1:0] lenTable,
        input int unsigned                regIdx,
        input int unsigned                cntW,
        input int unsigned                maxLen
    );
        int unsigned entry;
        entry = 0;
        for (int unsigned b = 0; b < 32; b++) begin
            if (b < cntW) begin
                entry[b] = lenTable[regIdx*cntW + b];
            end
        end
        if (entry == 0) begin
            return 1;
        end
        if (entry > maxLen) begin
            return maxLen;
        end
        return entry;
    endfunction

endpackage

// File: rtl/regfile_host_ctrl_if.sv
// Host-side valid/ready channels: header/payload words in, read words out.
interface regfile_host_ctrl_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/regfile_host_ctrl_word_shadow_buf.sv
// REG_W shadow register built from WORD_W slices: clear, full snapshot, single-word load, word-select read.
module word_shadow_buf import regfile_host_pkg::*; #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 256,
    parameter int IDX_W  = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              snapEn,
    input  logic [REG_W-1:0]  snapData,
    input  logic              wordWe,
    input  logic [IDX_W-1:0]  wordIdx,
    input  logic [WORD_W-1:0] wordIn,
    output logic [REG_W-1:0]  shadow,
    output logic [WORD_W-1:0] wordOut
);
    localparam int NWORDS = REG_W / WORD_W;

    for (genvar gi = 0; gi < NWORDS; gi++) begin : gWord
        logic [WORD_W-1:0] wordReg;

        // Clear wins over snapshot, snapshot over a single-word load.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                wordReg <= '0;
            end else if (clear) begin
                wordReg <= '0;
            end else if (snapEn) begin
                wordReg <= snapData[gi*WORD_W +: WORD_W];
            end else if (wordWe && (wordIdx == IDX_W'(gi))) begin
                wordReg <= wordIn;
            end
        end

        assign shadow[gi*WORD_W +: WORD_W] = wordReg;
    end

    assign wordOut = shadow[wordIdx*WORD_W +: WORD_W];

endmodule

// File: rtl/regfile_host_ctrl.sv
// Word-serial host front end for the coprocessor register file (header decode, read streaming, write assembly).
// Optional abort input is enabled by defining REGFILE_HOST_CTRL_ABORT_EN.
module regfile_host_ctrl import regfile_host_pkg::*; #(
    parameter int WORD_W   = 32,
    parameter int REG_W    = 256,
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 4,
    parameter logic [NUM_REGS*CNT_W-1:0] LEN_TABLE = {NUM_REGS{CNT_W'(REG_W/WORD_W)}},
    localparam int SEL_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    regfile_host_ctrl_if.slave  host,
`ifdef REGFILE_HOST_CTRL_ABORT_EN
    input  logic                abort,
`endif
    output logic [SEL_W-1:0]    dp_sel,
    output logic [NUM_REGS-1:0] dp_we,
    output logic [REG_W-1:0]    dp_wdata,
    input  logic [REG_W-1:0]    dp_rdata,
    output logic                busy
);
    localparam int WPR   = REG_W / WORD_W;
    localparam int IDX_W = (WPR > 1) ? $clog2(WPR) : 1;
    localparam logic [LEN_TABLE_MAX_W-1:0] LEN_TABLE_EXT = LEN_TABLE_MAX_W'(LEN_TABLE);

    // Burst lengths are stored as last word index so the counter compare needs no subtraction.
    logic [IDX_W-1:0] lastIdxTable [NUM_REGS];
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gLen
        assign lastIdxTable[gi] = IDX_W'(len_lookup(LEN_TABLE_EXT, gi, CNT_W, WPR) - 1);
    end

    ctrlState_t       stateReg, stateNext;
    logic [IDX_W-1:0] kReg, kNext;
    logic [IDX_W-1:0] lastReg, lastNext;
    logic [SEL_W-1:0] selReg, selNext;

    logic             abortHit;
    logic             opWrite;
    logic [SEL_W-1:0] hdrSel;
    logic             hdrSelOk;
    logic             shadowClear, snapEn, wordWe, weEn, inReady, outValid;
    logic [WORD_W-1:0] wordOut;

`ifdef REGFILE_HOST_CTRL_ABORT_EN
    assign abortHit = abort;
`else
    assign abortHit = 1'b0;
`endif

    assign opWrite  = host.in_data[WORD_W-HDR_OP_OFS];
    assign hdrSel   = host.in_data[WORD_W-HDR_SEL_OFS -: SEL_W];
    assign hdrSelOk = int'(hdrSel) < NUM_REGS;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateReg <= IDLE;
            kReg     <= '0;
            lastReg  <= '0;
            selReg   <= '0;
        end else begin
            stateReg <= stateNext;
            kReg     <= kNext;
            lastReg  <= lastNext;
            selReg   <= selNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        kNext       = kReg;
        lastNext    = lastReg;
        selNext     = selReg;
        shadowClear = 1'b0;
        snapEn      = 1'b0;
        wordWe      = 1'b0;
        weEn        = 1'b0;
        inReady     = 1'b0;
        outValid    = 1'b0;
        case (stateReg)
            IDLE: begin
                inReady = 1'b1;
                // An out-of-range select is consumed without leaving IDLE.
                if (host.in_valid && hdrSelOk) begin
                    selNext  = hdrSel;
                    lastNext = lastIdxTable[hdrSel];
                    kNext    = '0;
                    if (opWrite) begin
                        shadowClear = 1'b1;
                        stateNext   = WR_FILL;
                    end else begin
                        stateNext   = RD_LOAD;
                    end
                end
            end
            RD_LOAD: begin
                snapEn    = 1'b1;
                kNext     = '0;
                stateNext = RD_SEND;
            end
            RD_SEND: begin
                outValid = 1'b1;
                if (host.out_ready) begin
                    if (kReg == lastReg) begin
                        kNext     = '0;
                        stateNext = IDLE;
                    end else begin
                        kNext = kReg + IDX_W'(1);
                    end
                end
            end
            WR_FILL: begin
                inReady = 1'b1;
                if (host.in_valid) begin
                    wordWe = 1'b1;
                    if (kReg == lastReg) begin
                        kNext     = '0;
                        stateNext = WR_COMMIT;
                    end else begin
                        kNext = kReg + IDX_W'(1);
                    end
                end
            end
            WR_COMMIT: begin
                weEn      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        // Abort overrides everything decided above, including a same-cycle handshake or commit.
        if (abortHit) begin
            stateNext   = IDLE;
            kNext       = '0;
            lastNext    = lastReg;
            selNext     = selReg;
            shadowClear = 1'b0;
            snapEn      = 1'b0;
            wordWe      = 1'b0;
            weEn        = 1'b0;
        end
    end

    word_shadow_buf #(
        .WORD_W (WORD_W),
        .REG_W  (REG_W),
        .IDX_W  (IDX_W)
    ) uShadow (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (shadowClear),
        .snapEn   (snapEn),
        .snapData (dp_rdata),
        .wordWe   (wordWe),
        .wordIdx  (kReg),
        .wordIn   (host.in_data),
        .shadow   (dp_wdata),
        .wordOut  (wordOut)
    );

    assign host.in_ready  = inReady;
    assign host.out_valid = outValid;
    assign host.out_data  = wordOut;
    assign host.out_last  = outValid && (kReg == lastReg);
    assign dp_sel         = selReg;
    assign dp_we          = weEn ? (NUM_REGS'(1) << selReg) : '0;
    assign busy           = (stateReg != IDLE);

endmodule

// File: tb/tb_regfile_host_ctrl.sv
// Directed bench for regfile_host_ctrl with a read-word / commit scoreboard and a behavioural register file.
module tb_regfile_host_ctrl;
    localparam int WORD_W   = 32;
    localparam int REG_W    = 256;
    localparam int NUM_REGS = 16;
    localparam int CNT_W    = 4;
    // Entry 3 = 0 (reads as 1), entry 7 = 15 (clamps to 8), entry 12 = 5, all others 8.
    localparam logic [63:0] LEN_TABLE = 64'h8885_8888_F888_0888;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } outExp_t;

    typedef struct packed {
        logic [15:0]  we;
        logic [255:0] wdata;
    } weExp_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    dp_sel;
    logic [15:0]   dp_we;
    logic [255:0]  dp_wdata;
    logic [255:0]  dp_rdata;
    logic          busy;
`ifdef REGFILE_HOST_CTRL_ABORT_EN
    logic          abort = 1'b0;
`endif

    regfile_host_ctrl_if #(.WORD_W(WORD_W)) host ();

    regfile_host_ctrl #(
        .WORD_W    (WORD_W),
        .REG_W     (REG_W),
        .NUM_REGS  (NUM_REGS),
        .CNT_W     (CNT_W),
        .LEN_TABLE (LEN_TABLE)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .host     (host),
`ifdef REGFILE_HOST_CTRL_ABORT_EN
        .abort    (abort),
`endif
        .dp_sel   (dp_sel),
        .dp_we    (dp_we),
        .dp_wdata (dp_wdata),
        .dp_rdata (dp_rdata),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    // Behavioural datapath register file.
    logic [255:0] dpRegs [16];
    assign dp_rdata = dpRegs[dp_sel];
    always @(posedge clock) begin
        for (int i = 0; i < 16; i++) begin
            if (dp_we[i]) dpRegs[i] <= dp_wdata;
        end
    end

    outExp_t      outQ[$];
    weExp_t       weQ[$];
    logic [255:0] expRegs [16];
    logic [31:0]  pay [8];
    int           errors = 0;
    int           checks = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    outExp_t     monE;
    weExp_t      monW;
    logic [31:0] stallData;
    logic        stallLast;
    logic        stallPending = 1'b0;
    always @(negedge clock) begin
        if (reset_n) begin
            if (stallPending && host.out_valid) begin
                check("stall_data", 256'(host.out_data), 256'(stallData));
                check("stall_last", 256'(host.out_last), 256'(stallLast));
            end
            stallPending = host.out_valid && !host.out_ready;
            stallData    = host.out_data;
            stallLast    = host.out_last;
            if (host.out_valid && host.out_ready) begin
                check("out_expected", 256'(outQ.size() != 0), 256'(1'b1));
                if (outQ.size() != 0) begin
                    monE = outQ.pop_front();
                    check("out_data", 256'(host.out_data), 256'(monE.data));
                    check("out_last", 256'(host.out_last), 256'(monE.last));
                end
            end
            if (dp_we != 16'h0) begin
                check("commit_expected", 256'(weQ.size() != 0), 256'(1'b1));
                if (weQ.size() != 0) begin
                    monW = weQ.pop_front();
                    check("dp_we", 256'(dp_we), 256'(monW.we));
                    check("dp_wdata", dp_wdata, monW.wdata);
                end
            end
        end else begin
            stallPending = 1'b0;
        end
    end

    function automatic int expLen(input int sel);
        if (sel == 3) return 1;
        if (sel == 12) return 5;
        return 8;
    endfunction

    function automatic logic [31:0] hdr(input bit wr, input int sel);
        logic [31:0] h;
        h        = '0;
        h[31]    = wr;
        h[30:27] = sel[3:0];
        return h;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_word(input logic [31:0] d);
        bit accepted;
        accepted      = 1'b0;
        host.in_valid = 1'b1;
        host.in_data  = d;
        for (int t = 0; t < 50; t++) begin
            accepted = host.in_ready;
            tick();
            if (accepted) break;
        end
        host.in_valid = 1'b0;
        check("in_accept", 256'(accepted), 256'(1'b1));
    endtask

    task automatic do_write(input int sel, input int gapMax);
        int     n;
        weExp_t e;
        n       = expLen(sel);
        e.we    = 16'(1) << sel;
        e.wdata = '0;
        for (int i = 0; i < n; i++) e.wdata[i*32 +: 32] = pay[i];
        weQ.push_back(e);
        expRegs[sel] = e.wdata;
        send_word(hdr(1'b1, sel));
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gapMax)) tick();
            send_word(pay[i]);
        end
        check("busy_in_commit", 256'(busy), 256'(1'b1));
        check("dp_we_pulse", 256'(dp_we), 256'(e.we));
        tick();
        check("busy_after_commit", 256'(busy), 256'(1'b0));
        check("dp_we_single", 256'(dp_we), 256'(16'h0));
        check("in_ready_idle", 256'(host.in_ready), 256'(1'b1));
        $display("write reg %0d words=%0d gapMax=%0d", sel, n, gapMax);
    endtask

    task automatic do_read(input int sel, input bit stall);
        int         n;
        bit         done;
        logic [3:0] pat;
        outExp_t    e;
        pat  = 4'b1001;
        n    = expLen(sel);
        done = 1'b0;
        for (int i = 0; i < n; i++) begin
            e.data = expRegs[sel][i*32 +: 32];
            e.last = (i == n - 1);
            outQ.push_back(e);
        end
        host.out_ready = 1'b1;
        send_word(hdr(1'b0, sel));
        check("rd_load_no_valid", 256'(host.out_valid), 256'(1'b0));
        check("rd_in_ready_low", 256'(host.in_ready), 256'(1'b0));
        for (int t = 0; t < 200; t++) begin
            host.out_ready = stall ? pat[t % 4] : 1'b1;
            tick();
            if (t == 0) check("rd_first_valid", 256'(host.out_valid), 256'(1'b1));
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        host.out_ready = 1'b0;
        check("rd_done", 256'(done), 256'(1'b1));
        check("rd_drained", 256'(outQ.size()), 256'(0));
        $display("read reg %0d words=%0d stall=%0d", sel, n, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        host.in_valid  = 1'b0;
        host.in_data   = '0;
        host.out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", 256'(host.in_ready), 256'(1'b1));
        check("rst_out_valid", 256'(host.out_valid), 256'(1'b0));
        check("rst_busy", 256'(busy), 256'(1'b0));
        check("rst_dp_we", 256'(dp_we), 256'(16'h0));
        check("rst_dp_wdata", dp_wdata, 256'(0));
        reset_n = 1'b1;
        tick();

        // Reg 5 with payload 0..7, then plain and stalled reads.
        for (int i = 0; i < 8; i++) pay[i] = 32'(i);
        do_write(5, 0);
        check("reg5_header_value", 256'(hdr(1'b1, 5)), 256'(32'hA800_0000));
        do_read(5, 1'b0);
        do_read(5, 1'b1);

        // Short entry for reg 12: five words, upper words zero.
        for (int i = 0; i < 8; i++) pay[i] = $urandom;
        do_write(12, 0);
        check("reg12_upper_zero", 256'(dpRegs[12][255:160]), 256'(0));
        do_read(12, 1'b1);

        // Zero entry (reg 3) reads as one word; oversize entry (reg 7) clamps to eight.
        for (int i = 0; i < 8; i++) pay[i] = $urandom;
        do_write(3, 2);
        do_read(3, 1'b0);
        for (int i = 0; i < 8; i++) pay[i] = $urandom;
        do_write(7, 3);
        do_read(7, 1'b1);

        // Gapped rewrite of reg 5 with the original payload.
        for (int i = 0; i < 8; i++) pay[i] = 32'(i);
        do_write(5, 3);
        do_read(5, 1'b0);

        // Reset after three of eight write words: no commit, reg 2 keeps its old contents.
        for (int i = 0; i < 8; i++) pay[i] = $urandom;
        do_write(2, 0);
        send_word(hdr(1'b1, 2));
        for (int i = 0; i < 3; i++) send_word(32'hDEAD_0000 + 32'(i));
        reset_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 256'(host.in_ready), 256'(1'b1));
        check("mid_rst_out_valid", 256'(host.out_valid), 256'(1'b0));
        check("mid_rst_out_last", 256'(host.out_last), 256'(1'b0));
        check("mid_rst_out_data", 256'(host.out_data), 256'(0));
        check("mid_rst_busy", 256'(busy), 256'(1'b0));
        check("mid_rst_dp_sel", 256'(dp_sel), 256'(0));
        check("mid_rst_dp_wdata", dp_wdata, 256'(0));
        tick();
        tick();
        check("mid_rst_dp_we", 256'(dp_we), 256'(16'h0));
        reset_n = 1'b1;
        tick();
        do_read(2, 1'b0);
        for (int i = 0; i < 8; i++) pay[i] = $urandom;
        do_write(1, 1);
        do_read(1, 1'b1);

`ifdef REGFILE_HOST_CTRL_ABORT_EN
        // Abort while word k = 2 is on offer.
        for (int i = 0; i < 2; i++) begin
            monE.data = expRegs[5][i*32 +: 32];
            monE.last = 1'b0;
            outQ.push_back(monE);
        end
        host.out_ready = 1'b1;
        send_word(hdr(1'b0, 5));
        tick();
        tick();
        tick();
        host.out_ready = 1'b0;
        check("abort_pre_valid", 256'(host.out_valid), 256'(1'b1));
        check("abort_pre_last", 256'(host.out_last), 256'(1'b0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid_drop", 256'(host.out_valid), 256'(1'b0));
        check("abort_busy", 256'(busy), 256'(1'b0));
        check("abort_in_ready", 256'(host.in_ready), 256'(1'b1));
        check("abort_drained", 256'(outQ.size()), 256'(0));
        $display("abort read reg 5 at k=2");
        do_read(5, 1'b0);
`endif

        tick();
        check("final_outq_empty", 256'(outQ.size()), 256'(0));
        check("final_weq_empty", 256'(weQ.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
